// File: rtl/simplez_bus.sv
// simplez_bus: parametrised Simplez CPU core driving a single request/acknowledge memory bus.
// Latency (zero-wait bus): CLR/DEC/BR/BZ 2 cycles, LD/ADD/ST 3 cycles, WAIT 2+WAIT_CYCLES cycles.
// Backpressure: FETCH and MEM hold mem_req/addr/we/wdata stable until mem_ack; each wait state adds a cycle.
module simplez_bus #(
  parameter int DW          = 12,
  parameter int AW          = 9,
  parameter int WAIT_CYCLES = 1000,
  parameter int RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          resume,
  output logic          halted,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic          flag_z
);

  // Counter only needs to hold WAIT_CYCLES-1.
  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [AW-1:0] PC_INIT  = AW'(RESET_PC);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  localparam logic [2:0] OP_ST  = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_BR  = 3'd3;
  localparam logic [2:0] OP_BZ  = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [3:0] COE_WAIT = 4'hF;

  // Opcode and address fields must not overlap.
  if (DW < AW + 4) begin : g_bad_width
    $error("simplez_bus: DW must be at least AW+4");
  end
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("simplez_bus: WAIT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WAIT, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] ri;
  logic [CW-1:0] cnt;
  logic [2:0]    co;
  logic [3:0]    coe;
  logic [AW-1:0] cd;
  logic [AW-1:0] pc_inc;
  logic [DW-1:0] dec_val;
  logic [DW-1:0] add_val;
  logic          unused_ri;

  // Bits between CD and the opcode are deliberately ignored.
  assign co        = ri[DW-1:DW-3];
  assign coe       = ri[DW-1:DW-4];
  assign cd        = ri[AW-1:0];
  assign unused_ri = ^ri;
  assign pc_inc    = pc + AW'(1);
  assign dec_val   = acc - DW'(1);
  assign add_val   = acc + mem_rdata;
  assign mem_wdata = acc;

  // State register; reset restarts at FETCH.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (mem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        case (co)
          OP_ST, OP_LD, OP_ADD: state_nxt = S_MEM;
          OP_BR, OP_BZ, OP_CLR, OP_DEC: state_nxt = S_FETCH;
          default: state_nxt = (coe == COE_WAIT) ? S_WAIT : S_HALT;
        endcase
      end
      S_MEM:   if (mem_ack) state_nxt = S_FETCH;
      S_WAIT:  if (cnt == '0) state_nxt = S_FETCH;
      S_HALT:  if (resume) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Bus and status outputs; reset masks the request immediately to abandon a transaction.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    halted   = 1'b0;
    if (state == S_MEM) mem_addr = cd;
    if (!rst) begin
      case (state)
        S_FETCH: mem_req = 1'b1;
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (co == OP_ST);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: instruction register, accumulator, zero flag, pc and WAIT counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= PC_INIT;
      acc    <= '0;
      flag_z <= 1'b0;
      ri     <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ack) ri <= mem_rdata;
        S_EXEC: begin
          case (co)
            OP_CLR: begin
              acc    <= '0;
              flag_z <= 1'b1;
              pc     <= pc_inc;
            end
            OP_DEC: begin
              acc    <= dec_val;
              flag_z <= (dec_val == '0);
              pc     <= pc_inc;
            end
            OP_BR: pc <= cd;
            OP_BZ: pc <= flag_z ? cd : pc_inc;
            OP_ST, OP_LD, OP_ADD: ;
            default: if (coe == COE_WAIT) cnt <= CNT_INIT;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (co == OP_LD) begin
              acc    <= mem_rdata;
              flag_z <= (mem_rdata == '0);
            end else if (co == OP_ADD) begin
              acc    <= add_val;
              flag_z <= (add_val == '0);
            end
            pc <= pc_inc;
          end
        end
        S_WAIT: begin
          if (cnt == '0) pc <= pc_inc;
          else           cnt <= cnt - CW'(1);
        end
        S_HALT: if (resume) pc <= pc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_bus.sv
// tb_simplez_bus: directed bench for simplez_bus with a memory model and a write scoreboard.
// Latency: checks cycle counts of fetch, WAIT, HALT/resume and reset against fixed expectations.
// Backpressure: memory model inserts 0..max_lat wait states and can block acks to one address.
module tb_simplez_bus;
  localparam int DW = 12;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst, resume;
  logic          mem_req, mem_we, mem_ack, halted, flag_z;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, acc;

  always #5 clk = ~clk;

  simplez_bus #(.DW(DW), .AW(AW), .WAIT_CYCLES(5), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .resume(resume),
    .halted(halted), .acc(acc), .pc(pc), .flag_z(flag_z)
  );

  // Second core: wide configuration, zero-wait read-only memory, starts at the top address.
  logic        rst_b, req_b, we_b, halted_b, z_b;
  logic [9:0]  addr_b, pc_b;
  logic [15:0] wdata_b, rdata_b, acc_b;
  logic [15:0] mem_b [0:1023];

  simplez_bus #(.DW(16), .AW(10), .WAIT_CYCLES(3), .RESET_PC('h3FF)) dut_b (
    .clk(clk), .rst(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ack(req_b), .resume(1'b0),
    .halted(halted_b), .acc(acc_b), .pc(pc_b), .flag_z(z_b)
  );
  assign rdata_b = mem_b[addr_b];

  // Memory model for the main core.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          ld_en;
  logic [AW-1:0] ld_a;
  logic [DW-1:0] ld_d;
  int            max_lat;
  bit            block_ack;
  int            stall_left = 0;

  assign mem_ack   = mem_req && !(block_ack && mem_addr == AW'(10)) && (stall_left == 0);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (rst) stall_left <= 0;
    else if (mem_req && mem_ack) stall_left <= (max_lat == 0) ? 0 : int'($urandom_range(max_lat, 0));
    else if (mem_req && stall_left > 0) stall_left <= stall_left - 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back(wr_t'{a: a, d: d});
  endtask

  // Monitor: compares bus writes against the scoreboard and checks stall stability.
  bit            hold_vld = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_we;
  logic [DW-1:0] hold_wdata;

  always @(negedge clk) begin
    if (!rst && hold_vld) begin
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_addr", 32'(mem_addr), 32'(hold_addr));
      check("stall_we", 32'(mem_we), 32'(hold_we));
      check("stall_wdata", 32'(mem_wdata), 32'(hold_wdata));
    end
    hold_vld   = !rst && mem_req && !mem_ack;
    hold_addr  = mem_addr;
    hold_we    = mem_we;
    hold_wdata = mem_wdata;
    if (!rst && mem_req && mem_ack && mem_we) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(exp_e.a));
        check("wr_data", 32'(mem_wdata), 32'(exp_e.d));
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Called at a negedge; returns cycles until a read request to address a is seen.
  task automatic wait_fetch(input logic [AW-1:0] a, input int budget, output int n);
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == a) && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  int n, m;

  initial begin
    rst = 1'b1; resume = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    max_lat = 0; block_ack = 1'b0; rst_b = 1'b1;
    mem_b[10'h3FF] = 16'hA000;   // CLR
    mem_b[10'h000] = 16'hC000;   // DEC
    mem_b[10'h001] = 16'h83FF;   // BZ 0x3FF
    mem_b[10'h002] = 16'hE000;   // HALT

    load(9'h000, 12'h20A);  // LD 10
    load(9'h001, 12'h40B);  // ADD 11
    load(9'h002, 12'h00C);  // ST 12
    load(9'h003, 12'hE00);  // HALT
    load(9'h004, 12'hF00);  // WAIT
    load(9'h005, 12'h20D);  // LD 13
    load(9'h006, 12'h40E);  // ADD 14
    load(9'h007, 12'h820);  // BZ 0x20
    load(9'h00A, 12'h005);
    load(9'h00B, 12'h003);
    load(9'h00C, 12'h000);
    load(9'h00D, 12'hFFF);
    load(9'h00E, 12'h001);
    load(9'h00F, 12'h000);
    load(9'h020, 12'hC00);  // DEC
    load(9'h021, 12'h00F);  // ST 15
    load(9'h022, 12'hE00);  // HALT
    push_wr(9'd12, 12'h008);
    push_wr(9'd15, 12'hFFF);

    // Reset state
    @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_z", 32'(flag_z), 32'd0);
    check("rst_b_req", 32'(req_b), 32'd0);

    // Zero-wait LD/ADD/ST/HALT
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("first_fetch_req", 32'(mem_req), 32'd1);
    check("first_fetch_addr", 32'(mem_addr), 32'd0);
    n = 0;
    while (!halted && n < 200) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("halt_latency", n, 11);
    check("p1_acc", 32'(acc), 32'h008);
    check("p1_z", 32'(flag_z), 32'd0);
    check("p1_pc", 32'(pc), 32'd3);
    check("p1_mem12", 32'(mem[12]), 32'h008);

    // Resume 4 cycles after halt
    repeat (4) @(posedge clk);
    #1 resume = 1'b1;
    @(posedge clk); #1 resume = 1'b0;
    @(negedge clk);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_req", 32'(mem_req), 32'd1);
    check("resume_addr", 32'(mem_addr), 32'd4);

    // WAIT of 5 cycles, with a stray resume pulse inside it
    @(posedge clk); #1;
    @(posedge clk); #1 resume = 1'b1;
    @(posedge clk); #1 resume = 1'b0;
    @(negedge clk);
    wait_fetch(9'd5, 20, n);
    check("wait_cycles", n + 3, 7);
    check("wait_pc", 32'(pc), 32'd5);

    // ADD overflow to zero, then BZ taken
    wait_fetch(9'd7, 50, n);
    check("ovf_acc", 32'(acc), 32'h000);
    check("ovf_z", 32'(flag_z), 32'd1);
    wait_fetch(9'h20, 10, n);
    check("bz_taken_cycles", n, 2);
    wait_fetch(9'h21, 10, n);
    check("dec_acc", 32'(acc), 32'hFFF);
    check("dec_z", 32'(flag_z), 32'd0);
    wait_fetch(9'h22, 20, n);
    check("st_cycles", n, 3);

    // Resume during the EXEC cycle that enters HALT is ignored
    @(posedge clk); #1 resume = 1'b1;
    @(posedge clk); #1 resume = 1'b0;
    @(negedge clk);
    check("halt_entry_halted", 32'(halted), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'h22);
    check("wr_all_seen", exp_q.size(), 0);

    // Reset during a stalled MEM
    @(posedge clk); #1 rst = 1'b1; block_ack = 1'b1;
    load(9'h00C, 12'h000);
    @(negedge clk);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_req", 32'(mem_req), 32'd0);
    push_wr(9'd12, 12'h008);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    wait_fetch(9'd10, 10, n);
    check("stall_mem_reached", n, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stalled_req", 32'(mem_req), 32'd1);
    check("stalled_addr", 32'(mem_addr), 32'd10);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("abort_req_drop", 32'(mem_req), 32'd0);
    block_ack = 1'b0;
    exp_q.delete();
    max_lat = 5;
    push_wr(9'd12, 12'h008);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("refetch_req", 32'(mem_req), 32'd1);
    check("refetch_addr", 32'(mem_addr), 32'd0);
    check("refetch_acc", 32'(acc), 32'd0);

    // Same program under random wait states
    n = 0;
    while (!halted && n < 400) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("rnd_halted", 32'(halted), 32'd1);
    check("rnd_acc", 32'(acc), 32'h008);
    check("rnd_z", 32'(flag_z), 32'd0);
    check("rnd_pc", 32'(pc), 32'd3);
    check("rnd_mem12", 32'(mem[12]), 32'h008);
    check("rnd_wr_all_seen", exp_q.size(), 0);

    // Wide core: pc wrap, DEC to all ones, BZ not taken
    @(posedge clk); #1 rst_b = 1'b0;
    @(negedge clk);
    check("b_fetch_top", 32'(addr_b), 32'h3FF);
    check("b_fetch_req", 32'(req_b), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_wrap_addr", 32'(addr_b), 32'h000);
    check("b_wrap_pc", 32'(pc_b), 32'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_dec_acc", 32'(acc_b), 32'hFFFF);
    check("b_dec_z", 32'(z_b), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_bz_not_taken", 32'(addr_b), 32'h002);
    m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_halted", 32'(halted_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
